// File: rtl/mx_pkg.sv
// mx_pkg: types and constants shared by the MX block quantiser.
//   INT_W/SCALE_W/OUT_W : input element, scale and output element widths
//   SHIFT_BASE          : fixed extra shift from the input to the output grid
//   D_W                 : width of a shift distance, (2^SCALE_W - 1) + SHIFT_BASE
//                         can never wrap
//   state_e, elem_t     : controller state and one buffered element
//   calc_d()            : shift distance of one element against the block maximum
package mx_pkg;

  localparam int INT_W      = 24;
  localparam int SCALE_W    = 8;
  localparam int OUT_W      = 8;
  localparam int SHIFT_BASE = INT_W - OUT_W;
  localparam int D_W        = $clog2((1 << SCALE_W) + SHIFT_BASE);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [INT_W-1:0] op;
    logic [SCALE_W-1:0]      scale;
  } elem_t;

  // Only called with mx >= sc, so the subtraction never goes negative.
  function automatic logic [D_W-1:0] calc_d(input logic [SCALE_W-1:0] mx,
                                            input logic [SCALE_W-1:0] sc);
    return D_W'(mx) - D_W'(sc) + D_W'(SHIFT_BASE);
  endfunction

endpackage

// File: rtl/mx_blk_quant_shr_rnd.sv
// shr_rnd: combinational arithmetic right shift with round-to-nearest-even
// and saturation to a signed OUT_W result.
//   op  : signed INT_W input element
//   d   : shift distance (any value; large distances flush toward zero)
//   res : rounded, saturated OUT_W element
module shr_rnd
  import mx_pkg::*;
(
  input  logic [INT_W-1:0] op,
  input  logic [D_W-1:0]   d,
  output logic [OUT_W-1:0] res
);

  // Two extra sign bits let a clamped distance of INT_W+1 put the guard bit
  // on a sign copy and still leave the whole operand in the sticky field,
  // which is exactly what infinite sign extension gives for any larger d.
  localparam int EXT_W = INT_W + 2;
  localparam int DMAX  = INT_W + 1;

  localparam logic signed [EXT_W-1:0] SMAX = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SMIN = ~SMAX;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] shifted;
  logic signed [EXT_W-1:0] rounded;
  logic [EXT_W-1:0]        gbit;
  logic [D_W-1:0]          dc;
  logic                    guard;
  logic                    sticky;
  logic                    up;

  always_comb begin
    ext     = {{2{op[INT_W-1]}}, op};
    dc      = (d > D_W'(DMAX)) ? D_W'(DMAX) : d;
    shifted = ext >>> dc;
    gbit    = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    if (dc != '0) begin
      gbit   = EXT_W'(1) << (dc - 1'b1);
      guard  = |(ext & gbit);
      sticky = |(ext & (gbit - 1'b1));
    end
    up      = guard && (sticky || shifted[0]);
    rounded = shifted + {{(EXT_W-1){1'b0}}, up};
    if (rounded > SMAX)
      res = SMAX[OUT_W-1:0];
    else if (rounded < SMIN)
      res = SMIN[OUT_W-1:0];
    else
      res = rounded[OUT_W-1:0];
  end

endmodule

// File: rtl/mx_blk_quant.sv
// mx_blk_quant: buffers one block of individually scaled elements, finds the
// largest scale, then emits every element re-expressed on that shared scale.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_vld/o_rdy            : input handshake (i_op, i_scale)
//   o_vld/i_rdy            : output handshake (o_elem, o_scale, o_last)
//   o_scale                : shared block scale, constant across the block
//   o_last                 : marks the final element of a block
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | accepting inputs, tracking max scale, cnt = write index
// DRAIN | no inputs; cnt = next element to load into the output register
module mx_blk_quant
  import mx_pkg::*;
#(
  parameter int BLK_SZ = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  output logic               o_rdy,
  input  logic [INT_W-1:0]   i_op,
  input  logic [SCALE_W-1:0] i_scale,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic [OUT_W-1:0]   o_elem,
  output logic [SCALE_W-1:0] o_scale,
  output logic               o_last
);

  localparam int CNT_W = $clog2(BLK_SZ + 1);
  localparam int IDX_W = (BLK_SZ > 1) ? $clog2(BLK_SZ) : 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCALE_W-1:0] max_scale;
  elem_t              buffer [BLK_SZ];

  elem_t              rd;
  logic [D_W-1:0]     d;
  logic [OUT_W-1:0]   q;
  logic               fill_acc;
  logic               load;

  // o_rdy is decoded from state so it drops the moment reset asserts.
  assign o_rdy    = (state == FILL) && !i_rst;
  assign fill_acc = i_vld && o_rdy;

  // Output register refills whenever it is empty or being emptied this cycle.
  assign load = (state == DRAIN) && (cnt < CNT_W'(BLK_SZ)) && (!o_vld || i_rdy);

  // Plain register array: the read below is combinational, no read latency.
  always_ff @(posedge i_clk) begin
    if (fill_acc)
      buffer[cnt[IDX_W-1:0]] <= '{op: i_op, scale: i_scale};
  end

  assign rd = buffer[cnt[IDX_W-1:0]];
  assign d  = calc_d(max_scale, rd.scale);

  shr_rnd u_shr_rnd (
    .op  (rd.op),
    .d   (d),
    .res (q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= FILL;
      cnt       <= '0;
      max_scale <= '0;
      o_vld     <= 1'b0;
      o_elem    <= '0;
      o_scale   <= '0;
      o_last    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fill_acc) begin
            if (i_scale > max_scale)
              max_scale <= i_scale;
            if (cnt == CNT_W'(BLK_SZ - 1)) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            o_vld   <= 1'b1;
            o_elem  <= q;
            o_scale <= max_scale;
            o_last  <= (cnt == CNT_W'(BLK_SZ - 1));
            cnt     <= cnt + 1'b1;
          end else if (o_vld && i_rdy) begin
            o_vld <= 1'b0;
            if (o_last) begin
              state     <= FILL;
              cnt       <= '0;
              max_scale <= '0;
              o_last    <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mx_blk_quant.sv
module tb_mx_blk_quant;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_vld;
  logic        o_rdy;
  logic [23:0] i_op;
  logic [7:0]  i_scale;
  logic        o_vld;
  logic        i_rdy;
  logic [7:0]  o_elem;
  logic [7:0]  o_scale;
  logic        o_last;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [23:0] v_op [4];
  logic [7:0]  v_sc [4];
  logic [7:0]  g_elem [4];
  logic [7:0]  g_scale [4];
  logic        g_last [4];
  int          g_cnt;
  int          g_lat;
  int          t_in;
  logic        g_rdy_after;
  logic        g_vld_after;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  mx_blk_quant #(.BLK_SZ(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_op    (i_op),
    .i_scale (i_scale),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_elem  (o_elem),
    .o_scale (o_scale),
    .o_last  (o_last)
  );

  // Presents v_op/v_sc one per cycle; t_in = cycle the last one is presented.
  task automatic send_block();
    for (int i = 0; i < 4; i++) begin
      i_vld   = 1'b1;
      i_op    = v_op[i];
      i_scale = v_sc[i];
      t_in    = cyc;
      @(posedge i_clk);
      #1;
    end
    i_vld = 1'b0;
  endtask

  // Drains one block with i_rdy held high, bounded to 40 cycles.
  task automatic collect();
    i_rdy = 1'b1;
    g_cnt = 0;
    g_lat = -1;
    for (int c = 0; c < 40 && g_cnt < 4; c++) begin
      @(negedge i_clk);
      if (o_vld === 1'b1) begin
        if (g_cnt == 0) g_lat = cyc - t_in;
        g_elem[g_cnt]  = o_elem;
        g_scale[g_cnt] = o_scale;
        g_last[g_cnt]  = o_last;
        g_cnt++;
      end
    end
    @(negedge i_clk);
    g_rdy_after = o_rdy;
    g_vld_after = o_vld;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_vld = 1'b0; i_rdy = 1'b0; i_op = '0; i_scale = '0;
    repeat (3) @(negedge i_clk);
    n_total++; if (o_rdy !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", o_rdy); else n_pass++;
    n_total++; if (o_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", o_vld); else n_pass++;
    n_total++; if (o_elem !== 8'h00) $display("FAIL reset_elem: got %h expected 00", o_elem); else n_pass++;
    n_total++; if (o_scale !== 8'h00) $display("FAIL reset_scale: got %h expected 00", o_scale); else n_pass++;
    n_total++; if (o_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", o_last); else n_pass++;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    n_total++; if (o_rdy !== 1'b1) $display("FAIL release_rdy: got %b expected 1", o_rdy); else n_pass++;
    @(negedge i_clk);
  endtask

  task automatic test_equal_scales();
    logic [7:0] exp_e [4];
    exp_e = '{8'h40, 8'h40, 8'h40, 8'h40};
    v_op = '{24'h400000, 24'h400000, 24'h400000, 24'h400000};
    v_sc = '{8'd10, 8'd10, 8'd10, 8'd10};
    send_block();
    collect();
    n_total++; if (g_cnt !== 4) $display("FAIL equal_count: got %0d expected 4", g_cnt); else n_pass++;
    n_total++; if (g_lat !== 2) $display("FAIL equal_latency: got %0d expected 2", g_lat); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd10, (i == 3)})
        $display("FAIL equal_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd10, (i == 3));
      else n_pass++;
    end
    n_total++; if (g_rdy_after !== 1'b1) $display("FAIL equal_rdy_after: got %b expected 1", g_rdy_after); else n_pass++;
    n_total++; if (g_vld_after !== 1'b0) $display("FAIL equal_vld_after: got %b expected 0", g_vld_after); else n_pass++;
  endtask

  task automatic test_mixed_scales();
    logic [7:0] exp_e [4];
    exp_e = '{8'h10, 8'h40, 8'h40, 8'h40};
    v_op = '{24'h400000, 24'h400000, 24'h400000, 24'h400000};
    v_sc = '{8'd8, 8'd10, 8'd10, 8'd10};
    send_block();
    collect();
    n_total++; if (g_cnt !== 4) $display("FAIL mixed_count: got %0d expected 4", g_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd10, (i == 3)})
        $display("FAIL mixed_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd10, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_rne_ties();
    logic [7:0] exp_e [4];
    exp_e = '{8'h02, 8'h02, 8'h03, 8'hFE};
    v_op = '{24'h018000, 24'h028000, 24'h028001, 24'hFE8000};
    v_sc = '{8'd10, 8'd10, 8'd10, 8'd10};
    send_block();
    collect();
    n_total++; if (g_cnt !== 4) $display("FAIL rne_count: got %0d expected 4", g_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd10, (i == 3)})
        $display("FAIL rne_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd10, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_e [4];
    exp_e = '{8'h7F, 8'h80, 8'h00, 8'h40};
    v_op = '{24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h400000};
    v_sc = '{8'd255, 8'd255, 8'd0, 8'd255};
    send_block();
    collect();
    n_total++; if (g_cnt !== 4) $display("FAIL sat_count: got %0d expected 4", g_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd255, (i == 3)})
        $display("FAIL sat_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd255, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_e [4];
    logic [7:0] hold_e;
    logic [7:0] hold_s;
    logic       hold_l;
    int         n;
    exp_e = '{8'h01, 8'h02, 8'h03, 8'h04};
    v_op = '{24'h010000, 24'h020000, 24'h030000, 24'h040000};
    v_sc = '{8'd10, 8'd10, 8'd10, 8'd10};
    send_block();
    i_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge i_clk);
      if (o_vld === 1'b1) begin
        g_elem[0] = o_elem; g_scale[0] = o_scale; g_last[0] = o_last; n = 1;
      end
    end
    // Stall on element 1 for five cycles.
    @(negedge i_clk);
    i_rdy  = 1'b0;
    hold_e = o_elem;
    hold_s = o_scale;
    hold_l = o_last;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      n_total++;
      if ({o_vld, o_rdy, o_elem, o_scale, o_last} !== {1'b1, 1'b0, hold_e, hold_s, hold_l})
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b %h/%h/%b expected vld=1 rdy=0 %h/%h/%b", c,
                 o_vld, o_rdy, o_elem, o_scale, o_last, hold_e, hold_s, hold_l);
      else n_pass++;
    end
    i_rdy = 1'b1;
    if (n == 1 && o_vld === 1'b1) begin
      g_elem[1] = o_elem; g_scale[1] = o_scale; g_last[1] = o_last; n = 2;
    end
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge i_clk);
      if (o_vld === 1'b1) begin
        g_elem[n] = o_elem; g_scale[n] = o_scale; g_last[n] = o_last; n++;
      end
    end
    n_total++; if (n !== 4) $display("FAIL bp_count: got %0d expected 4", n); else n_pass++;
    for (int i = 0; i < 4 && i < n; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd10, (i == 3)})
        $display("FAIL bp_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd10, (i == 3));
      else n_pass++;
    end
    @(negedge i_clk);
    n_total++; if (o_vld !== 1'b0) $display("FAIL bp_no_dup: got %b expected 0", o_vld); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] exp_e [4];
    exp_e = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 2; i++) begin
      i_vld = 1'b1; i_op = 24'h7FFFFF; i_scale = 8'd20;
      @(posedge i_clk);
      #1;
    end
    i_vld = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    n_total++; if (o_rdy !== 1'b0) $display("FAIL rstmid_rdy: got %b expected 0", o_rdy); else n_pass++;
    n_total++; if ({o_vld, o_elem, o_scale, o_last} !== 18'h0)
      $display("FAIL rstmid_outs: got %b/%h/%h/%b expected all zero", o_vld, o_elem, o_scale, o_last);
    else n_pass++;
    #2;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_total++; if (o_rdy !== 1'b1) $display("FAIL rstmid_rdy_after: got %b expected 1", o_rdy); else n_pass++;
    v_op = '{24'h010000, 24'h020000, 24'h030000, 24'h040000};
    v_sc = '{8'd10, 8'd10, 8'd10, 8'd10};
    send_block();
    collect();
    n_total++; if (g_cnt !== 4) $display("FAIL rstmid_count: got %0d expected 4", g_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g_elem[i], g_scale[i], g_last[i]} !== {exp_e[i], 8'd10, (i == 3)})
        $display("FAIL rstmid_elem%0d: got %h/%h/%b expected %h/%h/%b", i,
                 g_elem[i], g_scale[i], g_last[i], exp_e[i], 8'd10, (i == 3));
      else n_pass++;
    end
    n_total++; if (g_vld_after !== 1'b0) $display("FAIL rstmid_extra: got %b expected 0", g_vld_after); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_equal_scales();
    test_mixed_scales();
    test_rne_ties();
    test_saturation();
    test_backpressure();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
